muldiv_seq: RTL
===============

# muldiv_seq

Multi-cycle sequencer for the RV32M multiply/divide extension beside the base 32I ALU in the execute stage. It accepts one operation at a time from the pipeline and iterates a shared 32-bit add/subtract-and-shift datapath for 32 cycles. While it works it holds the pipeline stall. It delivers a registered 32-bit result with a one-cycle done strobe.

## Interface
- BITS, 32, operand/result width (common_params value; only 32 supported)
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request; sampled only in IDLE or DONE
- op  in  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- A_in  in  BITS  rs1 operand, captured on accepted start
- B_in  in  BITS  rs2 operand, captured on accepted start
- flush  in  1  synchronous abort (branch mispredict/exception)
- busy  out  1  high in RUN and FIX; drives pipeline stall
- done  out  1  one-cycle strobe, RESULT valid
- RESULT  out  BITS  operation result, held until next accepted start

## Operation
- States: IDLE, RUN, FIX, DONE.
- IDLE/DONE + start: latch op, A_in and B_in, plus sign flags.
  - Signed operand: MULH/DIV/REM sign both; MULHSU signs A only.
  - Store magnitudes, clear 64-bit accumulator, count=0.
  - Next state RUN, except for special divides, which go directly to DONE.
- Special divides, resolved at accept:
  - B=0: DIV/DIVU give 0xFFFFFFFF; REM/REMU give A.
  - DIV/REM with A=0x80000000, B=0xFFFFFFFF: DIV gives 0x80000000, REM gives 0.
- RUN multiply: radix-2 shift-add on unsigned magnitudes, one bit per cycle, 32 cycles.
- RUN divide: restoring shift-subtract on unsigned magnitudes, one quotient bit per cycle, 32 cycles.
- count increments each RUN cycle; at count=31, next state is FIX.
- FIX applies sign correction (two's-complement negate of the 64-bit product or 32-bit value):
  - Product is negated if the operand signs differ.
  - Quotient is negated if the signs differ.
  - Remainder takes the dividend sign.
- FIX selects the result:
  - MUL takes product[31:0]; MULH/MULHSU/MULHU take product[63:32].
  - DIV* takes the quotient; REM* takes the remainder.
  - The selected value is registered into RESULT.
- DONE asserts done for exactly one cycle.
  - start in DONE is accepted (back-to-back); otherwise next state is IDLE.
- start in RUN/FIX is ignored; no queueing.
- flush has priority over start: next state IDLE, no done, RESULT unchanged.
  - flush together with start in IDLE/DONE rejects the start.
- All arithmetic is modulo 2^BITS per RV32M; no exceptions or traps are raised.

## Timing
- Reset (rst_n low, asynchronous): state IDLE, busy=0, done=0, RESULT=0, count=0, accumulators 0.
- Start accepted at edge N (normal op):
  - busy=1 in cycles N+1..N+33 (32 RUN + 1 FIX).
  - done=1 and RESULT valid in cycle N+34.
- Special divide accepted at edge N: busy stays 0, done=1 in cycle N+1.
- busy is registered (state decode only), so the stall has no combinational path from start.
- Back-to-back: start during the DONE cycle yields the next done 34 cycles later; busy is 0 in that DONE cycle.
- rst_n asserted mid-RUN: immediate return to IDLE with reset values; no done.
- flush mid-RUN at edge M: busy=0 from cycle M+1; a new start is accepted at edge M+1.

## Test plan
- MUL A=7, B=-3 (0xFFFFFFFD) -> RESULT=0xFFFFFFEB; MULH same operands -> 0xFFFFFFFF; done exactly 34 cycles after start, busy high 33 cycles.
- MULHU A=B=0xFFFFFFFF -> 0xFFFFFFFE; MULHSU A=0xFFFFFFFF, B=0xFFFFFFFF -> 0xFFFFFFFF.
- DIV A=-7, B=2 -> 0xFFFFFFFD; REM same -> 0xFFFFFFFF; DIVU A=100, B=7 -> 14; REMU -> 2.
- Specials: DIV A=5, B=0 -> 0xFFFFFFFF; REMU A=5, B=0 -> 5; DIV A=0x80000000, B=0xFFFFFFFF -> 0x80000000; REM same -> 0. Each gives done 1 cycle after start with busy never high.
- start pulsed during RUN with different operands -> ignored, first result unchanged. flush at cycle 10 of RUN -> no done, busy=0 next cycle, RESULT holds its prior value. Immediate restart completes correctly.
- Reset asserted asynchronously mid-RUN -> all outputs 0 before the next clock edge. Then 1000 random op/operand pairs in back-to-back mode (start in DONE) checked against a behavioural RV32M model; zero mismatches required.

Source files
------------

// File: rtl/muldiv_seq.sv
// RV32M multiply/divide sequencer: one shared add/sub-and-shift step per cycle,
// 32 iterations, then a sign-fix cycle that registers RESULT and a done strobe.
module muldiv_seq #(
  parameter int BITS = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [BITS-1:0] A_in,
  input  logic [BITS-1:0] B_in,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [BITS-1:0] RESULT
);
  localparam int CW = $clog2(BITS);

  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

  state_t            state_q, state_d;
  logic [2:0]        op_q, op_d;
  logic              neg_q, neg_d;     // negate product / quotient
  logic              rsgn_q, rsgn_d;   // remainder takes dividend sign
  logic [2*BITS-1:0] acc_q, acc_d;
  logic [BITS-1:0]   b_q, b_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [BITS-1:0]   res_q, res_d;

  logic              sgn_a, sgn_b, sa, sb, by0, ovf, accept;
  logic [BITS-1:0]   a_mag, b_mag;
  logic [BITS:0]     sum, rem_sh, diff;
  logic [2*BITS-1:0] mul_nxt, div_nxt, prod;
  logic [BITS-1:0]   quo, rem, fix_res;

  always_comb begin
    sgn_a  = (op == 3'b001) || (op == 3'b010) || (op == 3'b100) || (op == 3'b110);
    sgn_b  = (op == 3'b001) || (op == 3'b100) || (op == 3'b110);
    sa     = sgn_a & A_in[BITS-1];
    sb     = sgn_b & B_in[BITS-1];
    a_mag  = sa ? -A_in : A_in;
    b_mag  = sb ? -B_in : B_in;
    by0    = op[2] && (B_in == '0);
    ovf    = op[2] && !op[0] && (A_in == {1'b1, {(BITS-1){1'b0}}}) && (B_in == '1);
    accept = start && !flush && ((state_q == IDLE) || (state_q == DONE));

    // Multiply: low half is the multiplier, shifted out as the product shifts in.
    sum     = {1'b0, acc_q[2*BITS-1:BITS]} + (acc_q[0] ? {1'b0, b_q} : '0);
    mul_nxt = {sum, acc_q[BITS-1:1]};
    // Divide: low half is the dividend, replaced by quotient bits from the right.
    rem_sh  = acc_q[2*BITS-1:BITS-1];
    diff    = rem_sh - {1'b0, b_q};
    div_nxt = {diff[BITS] ? rem_sh[BITS-1:0] : diff[BITS-1:0], acc_q[BITS-2:0], ~diff[BITS]};

    prod    = neg_q ? -acc_q : acc_q;
    quo     = neg_q ? -acc_q[BITS-1:0] : acc_q[BITS-1:0];
    rem     = rsgn_q ? -acc_q[2*BITS-1:BITS] : acc_q[2*BITS-1:BITS];
    fix_res = op_q[2] ? (op_q[1] ? rem : quo)
                      : ((op_q == 3'b000) ? prod[BITS-1:0] : prod[2*BITS-1:BITS]);
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    neg_d   = neg_q;
    rsgn_d  = rsgn_q;
    acc_d   = acc_q;
    b_d     = b_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    if (flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          state_d = IDLE;
          if (accept) begin
            op_d    = op;
            neg_d   = sa ^ sb;
            rsgn_d  = sa;
            acc_d   = {{BITS{1'b0}}, a_mag};
            b_d     = b_mag;
            cnt_d   = '0;
            state_d = RUN;
            // Zero divisor and signed overflow bypass the iteration entirely.
            if (by0) begin
              res_d   = op[1] ? A_in : '1;
              state_d = DONE;
            end else if (ovf) begin
              res_d   = op[1] ? '0 : A_in;
              state_d = DONE;
            end
          end
        end
        RUN: begin
          acc_d = op_q[2] ? div_nxt : mul_nxt;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CW'(BITS-1)) state_d = FIX;
        end
        FIX: begin
          res_d   = fix_res;
          state_d = DONE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      op_q    <= '0;
      neg_q   <= 1'b0;
      rsgn_q  <= 1'b0;
      acc_q   <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      neg_q   <= neg_d;
      rsgn_q  <= rsgn_d;
      acc_q   <= acc_d;
      b_q     <= b_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
    end
  end

  assign busy   = (state_q == RUN) || (state_q == FIX);
  assign done   = (state_q == DONE);
  assign RESULT = res_q;
endmodule
